vcve2_data_responder: RTL and testbench

VCVE2_DATA_RESPONDER -- requirements
Module: vcve2_data_responder

---
 rtl/vcve2_pkg.sv | 19 +
 rtl/vcve2_resp_ram.sv | 37 +++
 rtl/vcve2_data_responder.sv | 126 ++++++++++++
 tb/tb_vcve2_data_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vcve2_pkg
// Brief   : Shared types and constants for the vcve2 data responder.
// Revision: 1.0 - initial release
// ============================================================================
package vcve2_pkg;

    localparam int RESP_MAX_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } resp_stage_t;

endpackage
`default_nettype wire

// File: rtl/vcve2_resp_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vcve2_resp_ram
// Brief   : Word-wide storage with byte-enabled synchronous write and
//           combinational read. Contents are intentionally not reset.
// Revision: 1.0 - initial release
// ============================================================================
module vcve2_resp_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/vcve2_data_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vcve2_data_responder
// Brief   : Memory-backed data-bus responder with fixed response latency and
//           bounded outstanding requests. Define VCVE2_RESP_ADDR_ERR_EN to
//           flag out-of-range addresses instead of aliasing them.
// Revision: 1.0 - initial release
// ============================================================================
module vcve2_data_responder
    import vcve2_pkg::*;
#(
    parameter int          Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0001_0000,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int                 c_idx_w   = $clog2(Depth);
    localparam int                 c_cnt_w   = $clog2(MaxOutstanding + 1);
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MaxOutstanding);

    if (Latency < 1 || Latency > RESP_MAX_LATENCY) begin : g_chk_latency
        $error("Latency must be within 1..%0d", RESP_MAX_LATENCY);
    end
    if (MaxOutstanding < 1 || MaxOutstanding > Latency + 1) begin : g_chk_max_out
        $error("MaxOutstanding must be within 1..Latency+1");
    end
    if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_chk_depth
        $error("Depth must be a power of two and at least 4");
    end

    logic [c_cnt_w-1:0] r_cnt;
    resp_stage_t        r_pipe [Latency];
    resp_stage_t        w_stage_in;
    logic               w_accept;
    logic               w_resp_valid;
    logic               w_addr_err;
    logic               w_wr_en;
    logic [31:0]        w_offset;
    logic [c_idx_w-1:0] w_idx;
    logic [31:0]        w_ram_rdata;

    // Word index is taken from the offset, which wraps modulo Depth words
    assign w_offset = addr_i - BaseAddr;
    assign w_idx    = w_offset[c_idx_w+1:2];

`ifdef VCVE2_RESP_ADDR_ERR_EN
    localparam logic [31:0] c_span = 32'(Depth * 4);
    // Unsigned offset also catches addresses below BaseAddr via wrap-around
    assign w_addr_err = (w_offset >= c_span);
`else
    logic w_unused_offset;
    assign w_unused_offset = ^{w_offset[31:c_idx_w+2], w_offset[1:0]};
    assign w_addr_err      = 1'b0;
`endif

    assign gnt_o        = req_i & ~rst_i & (r_cnt < c_max_out);
    assign w_accept     = req_i & gnt_o;
    assign w_wr_en      = w_accept & we_i & ~w_addr_err;
    assign w_resp_valid = r_pipe[Latency-1].valid;

    vcve2_resp_ram #(
        .DEPTH (Depth)
    ) u_ram (
        .clk     (clk_i),
        .i_we    (w_wr_en),
        .i_be    (be_i),
        .i_waddr (w_idx),
        .i_wdata (wdata_i),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_stage_in = '0;
        if (w_accept) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.err   = w_addr_err;
            if (!we_i && !w_addr_err) begin
                w_stage_in.rdata = w_ram_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < Latency; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept && !w_resp_valid) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_resp_valid) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign rvalid_o = w_resp_valid;
    assign rdata_o  = r_pipe[Latency-1].rdata;
    assign err_o    = r_pipe[Latency-1].err;

endmodule
`default_nettype wire

// File: tb/tb_vcve2_data_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_vcve2_data_responder
// Brief   : Directed scoreboard bench for vcve2_data_responder (Latency=2,
//           MaxOutstanding=2); honours VCVE2_RESP_ADDR_ERR_EN if defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vcve2_data_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          LAT   = 2;
    localparam int          MAXO  = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int   cyc     = 0;
    int   vectors = 0;
    int   fails   = 0;
    exp_t sb_q[$];
    int   acc_q[$];

    vcve2_data_responder #(
        .Depth          (DEPTH),
        .BaseAddr       (BASE),
        .Latency        (LAT),
        .MaxOutstanding (MAXO)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a response shows up
    always @(negedge clk) begin
        exp_t e;
        if (rst_i === 1'b0) begin
            if (rvalid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, "_rdata"}, rdata_o, e.rdata);
                    chk({e.tag, "_err"}, {31'b0, err_o}, {31'b0, e.err});
                    chk({e.tag, "_cycle"}, cyc, e.due);
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    vectors++;
                    fails++;
                    $display("FAIL %s_missing: got rvalid=0 at cycle %0d, expected 1", e.tag, cyc);
                end
                chk("idle_outputs", {rdata_o[31:1], rdata_o[0] | err_o}, 32'h0);
            end
        end
    end

    // Issue one request, holding req until the predicted grant arrives
    task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err);
        bit   done  = 0;
        int   tries = 0;
        logic exp_gnt;
        exp_t e;
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wd;
        while (!done) begin
            @(negedge clk);
            while (acc_q.size() > 0 && acc_q[0] + LAT < cyc) void'(acc_q.pop_front());
            exp_gnt = (acc_q.size() < MAXO);
            chk({tag, "_gnt"}, {31'b0, gnt_o}, {31'b0, exp_gnt});
            if (exp_gnt) begin
                acc_q.push_back(cyc);
                e.rdata = exp_rdata;
                e.err   = exp_err;
                e.due   = cyc + LAT;
                e.tag   = tag;
                sb_q.push_back(e);
                done = 1;
            end
            tries++;
            if (!done && tries > 16) begin
                vectors++;
                fails++;
                $display("FAIL %s_grant_timeout: no grant after %0d cycles, expected grant", tag, tries);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            vectors++;
            fails++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [31:0] oor_rdata, alias_rdata;
        logic        oor_err;
`ifdef VCVE2_RESP_ADDR_ERR_EN
        oor_rdata   = 32'h0;
        oor_err     = 1'b1;
        alias_rdata = 32'h0BAD_F00D;
`else
        oor_rdata   = 32'hCAFE_F00D;
        oor_err     = 1'b0;
        alias_rdata = 32'h1357_2468;
`endif
        rst_i   = 1'b1;
        req_i   = 1'b1;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = BASE;
        wdata_i = 32'h0;

        #7;
        chk("reset_gnt", {31'b0, gnt_o}, 32'h0);
        chk("reset_rvalid", {31'b0, rvalid_o}, 32'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_err", {31'b0, err_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = 1'b0;
        @(posedge clk);
        #1;

        do_req("wr_deadbeef", 1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req("rd_deadbeef", 1'b0, 4'hF, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_req("wr_full",     1'b1, 4'hF, 32'h0001_0014, 32'h1122_3344, 32'h0, 1'b0);
        do_req("wr_byte0",    1'b1, 4'h1, 32'h0001_0014, 32'h0000_00AA, 32'h0, 1'b0);
        do_req("rd_byte0",    1'b0, 4'hF, 32'h0001_0014, 32'h0, 32'h1122_33AA, 1'b0);
        do_req("wr_5a",       1'b1, 4'hF, 32'h0001_0020, 32'h5A5A_5A5A, 32'h0, 1'b0);
        do_req("rd_5a",       1'b0, 4'hF, 32'h0001_0020, 32'h0, 32'h5A5A_5A5A, 1'b0);
        do_req("wr_word0",    1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_req("wr_word1",    1'b1, 4'hF, 32'h0001_0007, 32'h0BAD_F00D, 32'h0, 1'b0);
        do_req("rd_oor",      1'b0, 4'hF, 32'h0002_0000, 32'h0, oor_rdata, oor_err);
        do_req("wr_oor",      1'b1, 4'hF, 32'h0002_0004, 32'h1357_2468, 32'h0, oor_err);
        do_req("rd_word1",    1'b0, 4'hF, 32'h0001_0004, 32'h0, alias_rdata, 1'b0);
        drain();

        // Continuous request stream: grant pattern 1,1,0,1,1 is checked per cycle
        do_req("b2b_0", 1'b0, 4'hF, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_req("b2b_1", 1'b0, 4'hF, 32'h0001_0014, 32'h0, 32'h1122_33AA, 1'b0);
        do_req("b2b_2", 1'b0, 4'hF, 32'h0001_0020, 32'h0, 32'h5A5A_5A5A, 1'b0);
        do_req("b2b_3", 1'b0, 4'hF, 32'h0001_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        drain();

        // Reset lands in the cycle the outstanding read would respond
        do_req("rd_killed", 1'b0, 4'hF, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #2;
        req_i = 1'b1;
        rst_i = 1'b1;
        #1;
        chk("midreset_gnt", {31'b0, gnt_o}, 32'h0);
        chk("midreset_rvalid", {31'b0, rvalid_o}, 32'h0);
        chk("midreset_rdata", rdata_o, 32'h0);
        sb_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        do_req("rd_after_reset", 1'b0, 4'hF, 32'h0001_0020, 32'h0, 32'h5A5A_5A5A, 1'b0);
        drain();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
